sw_pio_responder: RTL and testbench

- Avalon-MM responder (slave) peripheral. The Nios II master reads board switch state through it.
- Replaces the stock switch PIO with debounce, edge capture and an optional interrupt.
- Instantiated at top level beside the Nios system. SW pins in; Avalon-MM slave signals exported to the system interconnect.

---
 rtl/sw_pio_responder.sv | 141 ++++++++++++++
 tb/tb_sw_pio_responder.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_pio_responder.sv
// sw_pio_responder: Avalon-MM switch PIO with two-flop synchroniser, per-bit
// debounce, edge capture (W1C) and an optional level interrupt.
// Optional feature macro: SW_PIO_IRQ_EN (builds IRQMASK and drives irq).
// Register map (word address): 0 DATA, 1 IRQMASK, 2 EDGECAP, 3 RAW.
module sw_pio_responder #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] sw_in,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] deb_dly_q, deb_dly_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] mask_rd;
  logic [31:0]      readdata_q, readdata_d;
  logic [31:0]      rd_word;

  // Synchroniser and delayed debounced copy for edge detection
  always_comb begin
    s1_d      = sw_in;
    s2_d      = s1_q;
    deb_dly_d = deb_q;
  end

  // Per-bit debounce: the counter only runs while the synchronised level
  // disagrees with the debounced one, and is forced to 0 when it accepts
  // the new level, so it never wraps.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [CW-1:0] cnt_q, cnt_d;
      logic          deb_nx;

      // Debounce counter and next debounced level for this bit
      always_comb begin
        cnt_d  = cnt_q + CW'(1);
        deb_nx = deb_q[gi];
        if (s2_q[gi] == deb_q[gi]) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          deb_nx = s2_q[gi];
          cnt_d  = '0;
        end
      end

      // Debounce counter register
      always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) cnt_q <= '0;
        else                cnt_q <= cnt_d;
      end

      assign deb_d[gi] = deb_nx;
    end
  endgenerate

  // Qualifying edge selection and EDGECAP update; a set beats a W1C clear
  always_comb begin
    if (EDGE_TYPE == 0)      edge_set = deb_q & ~deb_dly_q;
    else if (EDGE_TYPE == 1) edge_set = ~deb_q & deb_dly_q;
    else                     edge_set = deb_q ^ deb_dly_q;
    cap_clr    = (avs_write && (avs_address == 2'd2)) ? avs_writedata[WIDTH-1:0] : '0;
    edge_cap_d = (edge_cap_q & ~cap_clr) | edge_set;
  end

`ifdef SW_PIO_IRQ_EN
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;

  // IRQMASK write
  always_comb begin
    irq_mask_d = irq_mask_q;
    if (avs_write && (avs_address == 2'd1)) irq_mask_d = avs_writedata[WIDTH-1:0];
  end

  // IRQMASK register
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) irq_mask_q <= '0;
    else                irq_mask_q <= irq_mask_d;
  end

  assign mask_rd = irq_mask_q;
  assign irq     = |(edge_cap_q & irq_mask_q);
`else
  assign mask_rd = '0;
  assign irq     = 1'b0;
`endif

  // Only the low WIDTH write bits are ever meaningful
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  // Read mux from pre-write register values; zero when no read is issued
  always_comb begin
    rd_word = '0;
    case (avs_address)
      2'd0:    rd_word[WIDTH-1:0] = deb_q;
      2'd1:    rd_word[WIDTH-1:0] = mask_rd;
      2'd2:    rd_word[WIDTH-1:0] = edge_cap_q;
      default: rd_word[WIDTH-1:0] = s2_q;
    endcase
    readdata_d = avs_read ? rd_word : '0;
  end

  // State registers
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      deb_q      <= '0;
      deb_dly_q  <= '0;
      edge_cap_q <= '0;
      readdata_q <= '0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      deb_q      <= deb_d;
      deb_dly_q  <= deb_dly_d;
      edge_cap_q <= edge_cap_d;
      readdata_q <= readdata_d;
    end
  end

  assign avs_readdata = readdata_q;

endmodule

// File: tb/tb_sw_pio_responder.sv
// Testbench for sw_pio_responder (WIDTH=2, DEBOUNCE_CYCLES=4, EDGE_TYPE=0).
// Works with or without SW_PIO_IRQ_EN defined.
module tb_sw_pio_responder;

  localparam int W  = 2;
  localparam int D  = 4;
  localparam int ET = 0;
  localparam int HN = 8192;
`ifdef SW_PIO_IRQ_EN
  localparam bit IRQ_BUILT = 1'b1;
`else
  localparam bit IRQ_BUILT = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  sw    = '0;
  logic [1:0]    addr  = '0;
  logic          rd    = 1'b0;
  logic          wr    = 1'b0;
  logic [31:0]   wd    = '0;
  logic [31:0]   rdata;
  logic          irq;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  sw_pio_responder #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(ET)) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .sw_in        (sw),
    .avs_address  (addr),
    .avs_read     (rd),
    .avs_write    (wr),
    .avs_writedata(wd),
    .avs_readdata (rdata),
    .irq          (irq)
  );

  // Reference model: keeps the history of sampled pins and debounced values
  // per clock edge, and applies the rules directly on those histories.
  logic [W-1:0] hist  [HN];   // sw_in as sampled into the first sync stage at edge n
  logic [W-1:0] dhist [HN];   // debounced value after edge n
  int           n        = 2;
  int           rst_edge = 2;
  logic [W-1:0] m_deb  = '0;
  logic [W-1:0] m_cap  = '0;
  logic [W-1:0] m_mask = '0;
  logic [31:0]  m_rd   = '0;
  logic         m_irq  = 1'b0;

  initial begin
    for (int i = 0; i < HN; i++) begin
      hist[i]  = '0;
      dhist[i] = '0;
    end
  end

  always @(posedge clk) begin : p_model
    logic [W-1:0] s2_pre, new_deb, rising, falling, set_m, clr_m;
    logic [31:0]  regv;
    bit           all_diff;
    n = n + 1;
    if (n >= HN) begin
      $display("FAIL model_overflow n=%0d limit=%0d", n, HN);
      $fatal(1);
    end
    s2_pre = hist[n-2];
    regv   = '0;
    case (addr)
      2'd0:    regv[W-1:0] = m_deb;
      2'd1:    regv[W-1:0] = m_mask;
      2'd2:    regv[W-1:0] = m_cap;
      default: regv[W-1:0] = s2_pre;
    endcase
    if (!rst_n) begin
      hist[n] = '0; hist[n-1] = '0; dhist[n] = '0; dhist[n-1] = '0;
      rst_edge = n;
      m_deb = '0; m_cap = '0; m_mask = '0; m_rd = '0;
    end else begin
      m_rd    = rd ? regv : 32'h0;
      hist[n] = sw;
      new_deb = m_deb;
      // Flip when the synchronised level disagreed on each of the last D edges
      if (n - D >= rst_edge) begin
        for (int i = 0; i < W; i++) begin
          all_diff = 1'b1;
          for (int j = 0; j < D; j++)
            if (hist[n-2-j][i] == m_deb[i]) all_diff = 1'b0;
          if (all_diff) new_deb[i] = ~m_deb[i];
        end
      end
      rising  = dhist[n-1] & ~dhist[n-2];
      falling = ~dhist[n-1] & dhist[n-2];
      set_m   = (ET == 0) ? rising : (ET == 1) ? falling : (rising | falling);
      clr_m   = (wr && addr == 2'd2) ? wd[W-1:0] : '0;
      m_cap   = (m_cap & ~clr_m) | set_m;
      if (IRQ_BUILT && wr && addr == 2'd1) m_mask = wd[W-1:0];
      m_deb    = new_deb;
      dhist[n] = new_deb;
    end
    m_irq = |(m_cap & m_mask);
  end

  // One bus cycle: drive at negedge, return at the following negedge
  task automatic cycle(input logic r, input logic [1:0] a, input logic w, input logic [31:0] d);
    rd = r; addr = a; wr = w; wd = d;
    @(posedge clk);
    @(negedge clk);
    $display("txn t=%0t rst_n=%0b sw=%b rd=%0b wr=%0b addr=%0d wd=%h -> rdata=%h irq=%0b",
             $time, rst_n, sw, r, w, a, d, rdata, irq);
    rd = 1'b0; wr = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    rst_n = 1'b0; sw = 2'b11;
    repeat (3) cycle(1'b1, 2'd0, 1'b0, 32'h0);
    vectors++;
    if (rdata !== 32'h0 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state rdata=%h irq=%b expected rdata=0 irq=0", rdata, irq);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cycle(1'b1, 2'd0, 1'b0, 32'h0);
      exp = (k >= 7) ? 32'h3 : 32'h0;
      vectors++;
      if (rdata !== exp || rdata !== m_rd) begin
        miscompares++;
        $display("FAIL reset_data edge=%0d got=%h expected=%h model=%h", k, rdata, exp, m_rd);
      end
    end
    cycle(1'b1, 2'd2, 1'b0, 32'h0);
    vectors++;
    if (rdata !== 32'h3 || rdata !== m_rd) begin
      miscompares++;
      $display("FAIL reset_edgecap got=%h expected=3", rdata);
    end
    cycle(1'b0, 2'd2, 1'b1, 32'h3);
    cycle(1'b1, 2'd2, 1'b0, 32'h0);
    vectors++;
    if (rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_w1c got=%h expected=0", rdata);
    end
    sw = 2'b00;
    repeat (10) cycle(1'b1, 2'd0, 1'b0, 32'h0);
    cycle(1'b0, 2'd2, 1'b1, 32'h3);
    vectors++;
    if (m_deb !== 2'b00 || rdata !== m_rd) begin
      miscompares++;
      $display("FAIL reset_settle model_deb=%b rdata=%h model=%h", m_deb, rdata, m_rd);
    end
  endtask

  task automatic test_glitch();
    int ones = 0;
    for (int k = 1; k <= 8; k++) begin
      sw = (k <= 3) ? 2'b01 : 2'b00;
      cycle(1'b1, 2'd3, 1'b0, 32'h0);
      if (rdata[0] === 1'b1) ones++;
      vectors++;
      if (rdata !== m_rd) begin
        miscompares++;
        $display("FAIL glitch_raw k=%0d got=%h model=%h", k, rdata, m_rd);
      end
    end
    vectors++;
    if (ones != 3) begin
      miscompares++;
      $display("FAIL glitch_raw_width got=%0d cycles expected=3", ones);
    end
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, (k % 2 == 0) ? 2'd0 : 2'd2, 1'b0, 32'h0);
      vectors++;
      if (rdata !== 32'h0 || rdata !== m_rd) begin
        miscompares++;
        $display("FAIL glitch_reject k=%0d got=%h expected=0", k, rdata);
      end
    end
  endtask

  task automatic test_rise();
    sw = 2'b10;
    for (int k = 1; k <= 7; k++) begin
      cycle(1'b1, 2'd0, 1'b0, 32'h0);
      vectors++;
      if ((k == 6 && rdata !== 32'h0) || (k == 7 && rdata !== 32'h2) || rdata !== m_rd) begin
        miscompares++;
        $display("FAIL rise_data k=%0d got=%h model=%h", k, rdata, m_rd);
      end
    end
    cycle(1'b1, 2'd2, 1'b0, 32'h0);
    vectors++;
    if (rdata !== 32'h2 || irq !== m_irq) begin
      miscompares++;
      $display("FAIL rise_edgecap got=%h irq=%b expected=2 irq=%b", rdata, irq, m_irq);
    end
    cycle(1'b0, 2'd2, 1'b1, 32'h2);
    cycle(1'b1, 2'd2, 1'b0, 32'h0);
    vectors++;
    if (rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL rise_w1c got=%h expected=0", rdata);
    end
  endtask

  task automatic test_collision();
    sw = 2'b11;
    for (int k = 1; k <= 6; k++) cycle(1'b1, 2'd2, 1'b0, 32'h0);
    // The edge lands at the 7th edge; clear bit 0 in that same cycle
    cycle(1'b0, 2'd2, 1'b1, 32'h1);
    cycle(1'b1, 2'd2, 1'b0, 32'h0);
    vectors++;
    if (rdata !== 32'h1 || rdata !== m_rd) begin
      miscompares++;
      $display("FAIL collision_set_wins got=%h expected=1", rdata);
    end
  endtask

  task automatic test_irq();
    cycle(1'b0, 2'd2, 1'b1, 32'h3);
    sw = 2'b10;
    repeat (8) cycle(1'b1, 2'd0, 1'b0, 32'h0);
    cycle(1'b0, 2'd1, 1'b1, 32'h1);
    cycle(1'b0, 2'd2, 1'b1, 32'h3);
    sw = 2'b11;
    for (int k = 1; k <= 7; k++) begin
      cycle(1'b1, 2'd2, 1'b0, 32'h0);
      vectors++;
      if ((k == 6 && irq !== 1'b0) || (k == 7 && irq !== IRQ_BUILT) || irq !== m_irq) begin
        miscompares++;
        $display("FAIL irq_rise k=%0d irq=%b model=%b", k, irq, m_irq);
      end
    end
    cycle(1'b0, 2'd2, 1'b1, 32'h1);
    vectors++;
    if (irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_clear irq=%b expected=0", irq);
    end
    cycle(1'b0, 2'd1, 1'b1, 32'h0);
    sw = 2'b10;
    repeat (8) cycle(1'b0, 2'd0, 1'b0, 32'h0);
    sw = 2'b11;
    repeat (8) cycle(1'b0, 2'd0, 1'b0, 32'h0);
    cycle(1'b1, 2'd2, 1'b0, 32'h0);
    vectors++;
    if (rdata !== 32'h1 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL irq_masked rdata=%h irq=%b expected rdata=1 irq=0", rdata, irq);
    end
    cycle(1'b0, 2'd1, 1'b1, 32'hFFFF_FFFF);
    cycle(1'b1, 2'd1, 1'b0, 32'h0);
    vectors++;
    if (rdata !== (IRQ_BUILT ? 32'h3 : 32'h0) || irq !== IRQ_BUILT || irq !== m_irq) begin
      miscompares++;
      $display("FAIL irq_mask_rw rdata=%h irq=%b expected rdata=%h irq=%b",
               rdata, irq, IRQ_BUILT ? 32'h3 : 32'h0, IRQ_BUILT);
    end
    cycle(1'b0, 2'd1, 1'b1, 32'h0);
  endtask

  task automatic test_reset_mid();
    sw = 2'b00;
    repeat (10) cycle(1'b0, 2'd0, 1'b0, 32'h0);
    cycle(1'b0, 2'd2, 1'b1, 32'h3);
    sw = 2'b01;
    repeat (4) cycle(1'b1, 2'd0, 1'b0, 32'h0);
    rst_n = 1'b0;
    cycle(1'b1, 2'd0, 1'b0, 32'h0);
    rst_n = 1'b1;
    vectors++;
    if (rdata !== 32'h0 || irq !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_state rdata=%h irq=%b expected 0", rdata, irq);
    end
    for (int k = 1; k <= 7; k++) begin
      cycle(1'b1, 2'd0, 1'b0, 32'h0);
      vectors++;
      if ((k <= 6 && rdata !== 32'h0) || (k == 7 && rdata !== 32'h1) || rdata !== m_rd) begin
        miscompares++;
        $display("FAIL midreset_data k=%0d got=%h model=%h", k, rdata, m_rd);
      end
    end
  endtask

  task automatic test_random();
    int          hold = 0;
    logic        r, w;
    logic [1:0]  a;
    logic [31:0] d;
    for (int k = 0; k < 800; k++) begin
      if (hold == 0) begin
        sw   = W'($urandom);
        hold = $urandom_range(1, 9);
      end
      hold--;
      r = 1'($urandom_range(0, 1));
      a = 2'($urandom_range(0, 3));
      w = ($urandom_range(0, 3) == 0);
      d = $urandom;
      cycle(r, a, w, d);
      vectors++;
      if (rdata !== m_rd || irq !== m_irq) begin
        miscompares++;
        $display("FAIL random k=%0d rdata=%h irq=%b expected rdata=%h irq=%b",
                 k, rdata, irq, m_rd, m_irq);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_glitch();
    test_rise();
    test_collision();
    test_irq();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
